// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter: FSM state encoding, requester
// identifiers and a one-hot to requester-id helper.
// Build option: define DMEM_ARB_RR_EN to turn on round-robin arbitration when
// both requesters contend. Otherwise the CPU always wins.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_DBG = 1'b1;

  // Converts a one-hot grant into a requester id. An all-zero grant maps to CPU.
  function automatic req_id_t onehot_to_id(input logic [1:0] oh);
    return oh[1] ? REQ_DBG : REQ_CPU;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
// Combinational grant picker for the two data-memory requesters.
// Build option: DMEM_ARB_RR_EN selects round-robin on contention. If it is
// not defined, fixed priority is used and req0 wins.
// Ports:
//   valid_i        command valid, bit 0 = CPU, bit 1 = debug/loader
//   lock_active_i  a lock is held; only its owner may be granted
//   lock_owner_i   requester holding the lock
//   last_grant_i   requester accepted most recently (used only by round-robin)
//   grant_o        one-hot grant, zero when nothing is grantable
// ---------------------------------------------------------------------------
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       lock_active_i,
  input  req_id_t    lock_owner_i,
  input  req_id_t    last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (lock_active_i) begin
      // While a lock is held, the other requester stalls even if the owner is idle.
      grant_o[lock_owner_i] = valid_i[lock_owner_i];
    end else if (&valid_i) begin
`ifdef DMEM_ARB_RR_EN
      // The requester that was not served last wins the tie.
      grant_o = (last_grant_i == REQ_CPU) ? 2'b10 : 2'b01;
`else
      grant_o = 2'b01;
`endif
    end else begin
      grant_o = valid_i;
    end
  end

`ifndef DMEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Lets two requesters share a single-port data memory whose read data is
// available one cycle after the read command:
//   req0 = CPU load/store path, req1 = debug/program-loader port.
// Commands use a valid/ready handshake. An accepted read is followed by one
// response cycle. A lock lets one requester keep the memory across several
// accesses so a sequence of accesses appears atomic.
// Build option: DMEM_ARB_RR_EN selects round-robin on contention. This choice
// is made inside dmem_arb_pick.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/ready/we/lock/addr/wdata   command channel N (N = 0, 1)
//   rspN_valid/rdata               read response to requester N
//   mem_en/we/a/wd                 memory command, combinational from the grant
//   mem_rd                         memory read data, one cycle after mem_en
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  arb_state_t state_q, state_d;
  logic       lock_active_q, lock_active_d;
  req_id_t    lock_owner_q, lock_owner_d;
  req_id_t    rsp_owner_q, rsp_owner_d;
  req_id_t    last_grant_q, last_grant_d;

  logic [1:0] valid_vec;
  logic [1:0] pick_grant;
  logic [1:0] grant;
  req_id_t    grant_id;
  logic       accept;

  logic                  sel_we;
  logic                  sel_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign valid_vec = {req1_valid, req0_valid};

  dmem_arb_pick u_pick (
    .valid_i       (valid_vec),
    .lock_active_i (lock_active_q),
    .lock_owner_i  (lock_owner_q),
    .last_grant_i  (last_grant_q),
    .grant_o       (pick_grant)
  );

  // Commands are accepted only in IDLE. They are also blocked while reset is
  // held, so every output is zero during reset and does not wait for the edge.
  assign grant    = (state_q == IDLE && !rst) ? pick_grant : 2'b00;
  assign accept   = |grant;
  assign grant_id = onehot_to_id(grant);

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign sel_we    = (grant_id == REQ_DBG) ? req1_we    : req0_we;
  assign sel_lock  = (grant_id == REQ_DBG) ? req1_lock  : req0_lock;
  assign sel_addr  = (grant_id == REQ_DBG) ? req1_addr  : req0_addr;
  assign sel_wdata = (grant_id == REQ_DBG) ? req1_wdata : req0_wdata;

  assign mem_en = accept;
  assign mem_we = accept & sel_we;
  assign mem_a  = accept ? sel_addr  : '0;
  assign mem_wd = accept ? sel_wdata : '0;

  // Response demux. Only the owner of the outstanding read sees data.
  logic                  rsp_active;
  logic [1:0]            rsp_valid_vec;
  logic [DATA_WIDTH-1:0] rsp_rdata_arr [2];

  assign rsp_active = (state_q == RESP) && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      localparam req_id_t RID = (gi == 1) ? REQ_DBG : REQ_CPU;
      assign rsp_valid_vec[gi] = rsp_active && (rsp_owner_q == RID);
      assign rsp_rdata_arr[gi] = rsp_valid_vec[gi] ? mem_rd : '0;
    end
  endgenerate

  assign rsp0_valid = rsp_valid_vec[0];
  assign rsp0_rdata = rsp_rdata_arr[0];
  assign rsp1_valid = rsp_valid_vec[1];
  assign rsp1_rdata = rsp_rdata_arr[1];

  always_comb begin
    state_d       = state_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    rsp_owner_d   = rsp_owner_q;
    last_grant_d  = last_grant_q;

    case (state_q)
      IDLE: begin
        if (accept && !sel_we) begin
          state_d     = RESP;
          rsp_owner_d = grant_id;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      last_grant_d = grant_id;
      if (sel_lock) begin
        lock_active_d = 1'b1;
        lock_owner_d  = grant_id;
      end else if (lock_active_q && lock_owner_q == grant_id) begin
        lock_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lock_active_q <= 1'b0;
      lock_owner_q  <= REQ_CPU;
      rsp_owner_q   <= REQ_CPU;
      last_grant_q  <= REQ_DBG;
    end else begin
      state_q       <= state_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      rsp_owner_q   <= rsp_owner_d;
      last_grant_q  <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed testbench for dmem_arbiter. It includes a simple synchronous-read
// memory model. Words that were never written read back as 0xC0DE0000 + addr.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_lock  (req0_lock),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_lock  (req1_lock),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Memory model. The written flags give the initial pattern for unwritten words.
  logic [31:0] mem_arr [256];
  logic        written [256];

  always @(posedge clk) begin
    if (rst && mem_a == 32'h0) begin
      mem_rd <= mem_rd;
    end
    if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_a[9:2]] = mem_wd;
        written[mem_a[9:2]] = 1'b1;
      end else begin
        mem_rd <= written[mem_a[9:2]] ? mem_arr[mem_a[9:2]] : (32'hC0DE_0000 + mem_a);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-22s got=%08h exp=%08h ok", tag, got, exp);
    end else begin
      $display("FAIL %-22s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic lk,
                        input logic [31:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic lk,
                        input logic [31:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      written[i] = 1'b0;
      mem_arr[i] = 32'h0;
    end
    mem_rd = 32'h0;
    rst = 1'b1;
    drive0(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    drive1(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);

    // Reset state: nothing is granted even though both requesters are valid.
    tick(); tick();
    settle();
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;

    // 1: write followed by a read of the same word.
    tick();
    drive0(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    settle();
    check("t1_wr_ready", {31'b0, req0_ready}, 32'd1);
    check("t1_wr_mem_we", {31'b0, mem_we}, 32'd1);
    check("t1_wr_mem_a", mem_a, 32'h10);
    check("t1_wr_mem_wd", mem_wd, 32'hDEADBEEF);
    tick();
    drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    settle();
    check("t1_rd_ready", {31'b0, req0_ready}, 32'd1);
    check("t1_rd_mem_we", {31'b0, mem_we}, 32'd0);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("t1_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    check("t1_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
    check("t1_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    check("t1_resp_mem_en", {31'b0, mem_en}, 32'd0);

    // 2: both requesters read in the same cycle, repeated four times.
    for (int r = 0; r < 4; r++) begin
      tick();
      drive0(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      drive1(1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
      settle();
      check($sformatf("t2_r%0d_req0_ready", r), {31'b0, req0_ready}, 32'd1);
      check($sformatf("t2_r%0d_req1_wait", r), {31'b0, req1_ready}, 32'd0);
      tick();
      drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      settle();
      check($sformatf("t2_r%0d_rsp0", r), rsp0_rdata, 32'hC0DE0020);
      check($sformatf("t2_r%0d_req1_resp", r), {31'b0, req1_ready}, 32'd0);
      tick();
      settle();
      check($sformatf("t2_r%0d_req1_ready", r), {31'b0, req1_ready}, 32'd1);
      tick();
      drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      settle();
      check($sformatf("t2_r%0d_rsp1", r), rsp1_rdata, 32'hC0DE0024);
    end

    // 3: req1 takes the lock and idles. req0 stalls until req1 unlocks.
    tick();
    drive1(1'b1, 1'b1, 1'b1, 32'h40, 32'h12345678);
    settle();
    check("t3_lock_wr_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    settle();
    check("t3_req0_stall_a", {31'b0, req0_ready}, 32'd0);
    tick();
    settle();
    check("t3_req0_stall_b", {31'b0, req0_ready}, 32'd0);
    tick();
    drive1(1'b1, 1'b1, 1'b0, 32'h48, 32'h0BADF00D);
    settle();
    check("t3_unlock_ready", {31'b0, req1_ready}, 32'd1);
    check("t3_req0_stall_c", {31'b0, req0_ready}, 32'd0);
    tick();
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("t3_req0_ready", {31'b0, req0_ready}, 32'd1);
    check("t3_req0_mem_a", mem_a, 32'h44);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("t3_rsp0", rsp0_rdata, 32'hC0DE0044);

    // 4: five back-to-back writes, then read each word back.
    for (int i = 0; i < 5; i++) begin
      tick();
      drive0(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'hA5A50000 + 32'(i));
      settle();
      check($sformatf("t4_wr%0d_ready", i), {31'b0, req0_ready}, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      drive0(1'b1, 1'b0, 1'b0, 32'(i * 4), 32'h0);
      settle();
      check($sformatf("t4_rd%0d_ready", i), {31'b0, req0_ready}, 32'd1);
      tick();
      drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      settle();
      check($sformatf("t4_rd%0d_data", i), rsp0_rdata, 32'hA5A50000 + 32'(i));
    end

    // 5: reset during the response cycle of a locked req1 read.
    tick();
    drive1(1'b1, 1'b0, 1'b1, 32'h24, 32'h0);
    settle();
    check("t5_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 1'b0, 32'h28, 32'h0);
    rst = 1'b1;
    settle();
    check("t5_rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    check("t5_rst_rsp1_rdata", rsp1_rdata, 32'd0);
    check("t5_rst_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
    check("t5_rst_mem_en", {31'b0, mem_en}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("t5_req0_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("t5_rsp0", rsp0_rdata, 32'hC0DE0028);
    check("t5_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);

    // 6: locked read, then unlocking read by req0. req1 waits, then is served.
    tick();
    drive0(1'b1, 1'b0, 1'b1, 32'h30, 32'h0);
    drive1(1'b1, 1'b0, 1'b0, 32'h34, 32'h0);
    settle();
    check("t6_req0_ready_a", {31'b0, req0_ready}, 32'd1);
    check("t6_req1_wait_a", {31'b0, req1_ready}, 32'd0);
    tick();
    drive0(1'b1, 1'b0, 1'b0, 32'h38, 32'h0);
    settle();
    check("t6_rsp0_a", rsp0_rdata, 32'hC0DE0030);
    check("t6_rsp1_valid_a", {31'b0, rsp1_valid}, 32'd0);
    tick();
    settle();
    check("t6_req0_ready_b", {31'b0, req0_ready}, 32'd1);
    check("t6_req1_wait_b", {31'b0, req1_ready}, 32'd0);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("t6_rsp0_b", rsp0_rdata, 32'hC0DE0038);
    check("t6_rsp1_valid_b", {31'b0, rsp1_valid}, 32'd0);
    tick();
    settle();
    check("t6_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("t6_rsp1", rsp1_rdata, 32'hC0DE0034);
    check("t6_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
